// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic par_type);
    return (par_type == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Counter link and received-byte bus between the RX control FSM and its neighbours.
interface uart_rx_fsm_if;

  logic [4:0]                      edge_cnt_in;
  logic [3:0]                      bit_cnt_in;
  logic                            en_counter_out;
  logic                            cnt_clr_out;
  logic [uart_rx_pkg::DATA_BITS-1:0] p_data_out;
  logic                            data_valid_out;
  logic                            par_err_out;
  logic                            stp_err_out;

  modport master (
    input  edge_cnt_in, bit_cnt_in,
    output en_counter_out, cnt_clr_out, p_data_out, data_valid_out, par_err_out, stp_err_out
  );

  modport slave (
    output edge_cnt_in, bit_cnt_in,
    input  en_counter_out, cnt_clr_out, p_data_out, data_valid_out, par_err_out, stp_err_out
  );

endinterface

// File: rtl/uart_rx_data_sampler.sv
// Mid-bit sampler of the serial line; UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around mid.
// Latency: sampled_bit registered at edge mid (mid+1 with voting); no backpressure.
module uart_rx_data_sampler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic [4:0] prescale_in,
  input  logic [4:0] edge_cnt_in,
  output logic       sampled_bit
);

  logic [4:0] mid;
  logic       unused_prescale_lsb;

  assign mid                 = {1'b0, prescale_in[4:1]};
  assign unused_prescale_lsb = prescale_in[0];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s_early;
  logic s_mid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_early     <= 1'b0;
      s_mid       <= 1'b0;
      sampled_bit <= 1'b0;
    end else begin
      if (edge_cnt_in == mid - 5'd1) s_early <= rx_in;
      if (edge_cnt_in == mid)        s_mid   <= rx_in;
      if (edge_cnt_in == mid + 5'd1)
        sampled_bit <= (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sampled_bit <= 1'b0;
    end else if (edge_cnt_in == mid) begin
      sampled_bit <= rx_in;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX control: start/data/parity/stop sequencing against an external edge/bit counter.
// Latency: valid/error pulse one cycle after the stop (or parity) evaluation; no backpressure. Option: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_in,
  input  logic [4:0]        prescale_in,
  input  logic              par_en_in,
  input  logic              par_type_in,
  uart_rx_fsm_if.master     rx_if
);

  rx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   p_data_q;
  logic                   par_en_q, par_type_q;
  logic                   vld_q, perr_q, serr_q;
  logic                   sampled_bit;
  logic [4:0]             last;
  logic                   eval;

  logic en_counter, cnt_clr, latch_cfg, shift_en, load_data, set_perr, set_serr;

  assign last = prescale_in - 5'd1;
  assign eval = (rx_if.edge_cnt_in == last);

  uart_rx_data_sampler u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .prescale_in (prescale_in),
    .edge_cnt_in (rx_if.edge_cnt_in),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    en_counter = 1'b1;
    cnt_clr    = 1'b0;
    latch_cfg  = 1'b0;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    set_perr   = 1'b0;
    set_serr   = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so the counter never runs while the block is held in reset.
        en_counter = ~rx_in & reset_n;
        if (!rx_in) begin
          state_d   = START;
          latch_cfg = 1'b1;
        end
      end
      START: begin
        if (eval && rx_if.bit_cnt_in == 4'd0) begin
          if (!sampled_bit) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (eval) begin
          shift_en = 1'b1;
          if (rx_if.bit_cnt_in == 4'(DATA_BITS))
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (eval) begin
          if (sampled_bit != parity_bit(shift_q, par_type_q)) begin
            state_d  = IDLE;
            cnt_clr  = 1'b1;
            set_perr = 1'b1;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (eval) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          if (sampled_bit) load_data = 1'b1;
          else             set_serr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      vld_q      <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      if (latch_cfg) begin
        par_en_q   <= par_en_in;
        par_type_q <= par_type_in;
      end
      // LSB arrives first, so each new bit enters at the top and walks down.
      if (shift_en)  shift_q  <= {sampled_bit, shift_q[DATA_BITS-1:1]};
      if (load_data) p_data_q <= shift_q;
      vld_q  <= load_data;
      perr_q <= set_perr;
      serr_q <= set_serr;
    end
  end

  assign rx_if.en_counter_out = en_counter;
  assign rx_if.cnt_clr_out    = cnt_clr;
  assign rx_if.p_data_out     = p_data_q;
  assign rx_if.data_valid_out = vld_q;
  assign rx_if.par_err_out    = perr_q;
  assign rx_if.stp_err_out    = serr_q;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side control stage of the UART RX path. Drives the edge/bit counter and consumes its edge and bit counts. Samples the serial line, deserializes an 8-bit LSB-first frame, checks optional parity and the stop bit, and presents the received byte with a one-cycle valid pulse to the downstream synchronizer and register-file logic.

## Interface
- No parameters. Frame width is fixed at 8 data bits.
- clk  in  1  system/RX clock; runs at prescale × baud
- reset_n  in  1  asynchronous, active-low reset
- rx_in  in  1  serial line; already 2-flop synchronized to clk outside this block; idles high
- prescale_in  in  5  clocks per bit; legal values are even numbers 6..30 (8 and 16 are the supported modes); static while not IDLE
- par_en_in  in  1  parity bit present; latched at start detection
- par_type_in  in  1  0 = even, 1 = odd; latched at start detection
- edge_cnt_in  in  5  edge count from the counter
- bit_cnt_in  in  4  bit count from the counter
- en_counter_out  out  1  counter enable
- cnt_clr_out  out  1  counter synchronous clear; wired to the counter's clear/data_valid input
- p_data_out  out  8  received byte; holds its value until the next good frame
- data_valid_out  out  1  one-cycle pulse when a good frame completes
- par_err_out  out  1  one-cycle pulse on parity mismatch
- stp_err_out  out  1  one-cycle pulse on stop-bit error

## Operation
- Sampling uses `mid = prescale_in[4:1]` and `last = prescale_in - 1`, both 5-bit. `sampled_bit` is registered and updated during the bit.
- Bit evaluation happens at the cycle where `edge_cnt_in == last`.
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `en_counter_out = ~rx_in` (Mealy output).
  - When `rx_in == 0`, go to START and latch `par_en_in`/`par_type_in`. This cycle counts as edge 0.
- **START:**
  - At evaluation with `bit_cnt_in == 0`: if `sampled_bit == 0`, go to DATA.
  - Otherwise the start was a glitch: go to IDLE with `cnt_clr_out` asserted and no flags raised.
- **DATA:**
  - At each evaluation, shift right with `sampled_bit` inserted at bit 7.
  - At evaluation with `bit_cnt_in == 8`: go to PARITY if parity is enabled, else STOP.
- **PARITY:**
  - Expected bit is `^shift` for even parity, `~^shift` for odd.
  - Mismatch: go to IDLE, assert `cnt_clr_out`, set `par_err_out` next cycle, no valid.
  - Match: go to STOP.
- **STOP:**
  - `sampled_bit == 1`: `p_data_out <= shift`, `data_valid_out` pulses next cycle, go to IDLE.
  - `sampled_bit == 0`: `stp_err_out` pulses next cycle, `p_data_out` unchanged, go to IDLE.
  - In both cases `cnt_clr_out` is asserted in the evaluation cycle.
- `en_counter_out` is 1 in every non-IDLE state.
- `cnt_clr_out` is combinational and asserted only in a terminating evaluation cycle.

## Timing
- Reset values: state = IDLE; all outputs 0; `p_data_out = 8'h00`; shift register and sample registers cleared.
- Reset mid-frame aborts the frame silently, with no flags.
- Let cycle 0 be the first cycle with `rx_in` low in IDLE. Frame length is F = 10 bits (no parity) or 11 bits (parity).
  - Stop evaluation occurs at cycle F × prescale − 1.
  - `data_valid_out` / `stp_err_out` are high at cycle F × prescale.
  - Example: prescale 8, no parity gives the valid pulse at cycle 80.
- Back-to-back frames are supported:
  - A start bit seen in the cycle after stop evaluation is accepted.
  - The counter is already cleared at that point, because the clear takes effect at the evaluation edge.
- `data_valid_out`, `par_err_out` and `stp_err_out` are mutually exclusive and never high for more than one cycle.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Sample at edges mid−1, mid and mid+1.
  - `sampled_bit` = 2-of-3 majority, registered at edge mid+1.
- Not defined:
  - Single sample at edge `mid`.
  - Identical frame timing and outputs otherwise.

## Structure
- `uart_rx_pkg` holds:
  - `rx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - `DATA_BITS = 8`.
  - Parity-type constants `PAR_EVEN = 1'b0`, `PAR_ODD = 1'b1`.
- Natural sub-module: `uart_rx_data_sampler`.
  - Inputs: `rx_in`, `prescale_in`, `edge_cnt_in`.
  - Output: `sampled_bit`.
  - Contains the macro-selected majority logic.
- The FSM, shift register and checks remain in `uart_rx_fsm`.

## Test plan
- Prescale 8, no parity, byte 0xA5 with stop bit 1 → `p_data_out = 0xA5`, single `data_valid_out` pulse at cycle 80, no error flags.
- Prescale 16, even parity, byte 0x3C with parity bit 0 → valid pulse at cycle 176, `p_data_out = 0x3C`. Repeat with parity bit 1 → `par_err_out` pulse, `p_data_out` unchanged.
- Prescale 8, byte 0x5A with stop bit 0 → `stp_err_out` pulse at cycle 80, no valid, FSM back in IDLE.
- `rx_in` low for 2 cycles then high (glitch) → returns to IDLE at cycle 7 with `cnt_clr_out` high and no flags. Next real frame 0x81 is received correctly.
- With majority vote enabled, data bit 3 of 0xFF is forced low only at edge `mid` → 0xFF is received. Without the macro → 0xF7 is received.
- Two frames back-to-back (0x12 then 0x34), plus `reset_n` pulsed low mid-second frame:
  - Without the reset: valid pulses at cycles 80 and 160.
  - With the reset: only the first valid pulse appears, and all outputs are 0 during reset.
